// File: rtl/seq_mult_unit_pkg.sv
// Shared types for the iterative shift-add multiplier.
// Holds the FSM state encoding and the iteration-counter width helper.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..WIDTH-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_mult_unit_twos_abs.sv
// Conditional two's-complement negate: y = neg ? -x : x (mod 2^WIDTH).
// Used as magnitude extractor for operands and as the final result negate.
module twos_abs #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? ((~x) + WIDTH'(1'b1)) : x;

endmodule

// File: rtl/seq_mult_unit.sv
// Radix-2 shift-add multiplier, WIDTH cycles per product, valid/ready on both sides.
// Signed operands are multiplied as magnitudes and the product sign is restored at the end.
module seq_mult_unit
   import mult_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               op_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);

   state_t          state_reg;
   logic [PW-1:0]   mcand_reg;
   logic [WIDTH-1:0] mplier_reg;
   logic [PW-1:0]   acc_reg;
   logic [CW-1:0]   cnt_reg;
   logic            neg_reg;
   logic [PW-1:0]   product_reg;
   logic            in_ready_reg;
   logic            out_valid_reg;
   logic            busy_reg;

   logic             signed_op;
   logic             neg_in;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [PW-1:0]    acc_next;
   logic [PW-1:0]    result_next;

   assign signed_op = op_signed & SIGNED_EN;
   assign neg_in    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);

   // Magnitude of the most negative value wraps to 2^(W-1), which is correct read as unsigned.
   generate
      if (SIGNED_EN) begin : g_signed
         twos_abs #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(signed_op & a[WIDTH-1]), .y(a_abs));
         twos_abs #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(signed_op & b[WIDTH-1]), .y(b_abs));
      end else begin : g_unsigned
         assign a_abs = a;
         assign b_abs = b;
      end
   endgenerate

   assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

   twos_abs #(.WIDTH(PW)) u_neg_res (.x(acc_next), .neg(neg_reg), .y(result_next));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         mcand_reg     <= '0;
         mplier_reg    <= '0;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         neg_reg       <= 1'b0;
         product_reg   <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  mcand_reg    <= PW'(a_abs);
                  mplier_reg   <= b_abs;
                  neg_reg      <= neg_in;
                  acc_reg      <= '0;
                  cnt_reg      <= '0;
                  state_reg    <= CALC;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end
            CALC: begin
               // Always runs all WIDTH iterations so latency does not depend on the data.
               acc_reg    <= acc_next;
               mcand_reg  <= {mcand_reg[PW-2:0], 1'b0};
               mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
               cnt_reg    <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  product_reg   <= result_next;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign product   = product_reg;
   assign busy      = busy_reg;

endmodule
